sensores_multi: RTL and testbench
=================================

SENSORES_MULTI -- requirements
Module: sensores_multi

Interface
REQ-001 SHALL have parameter N_CANALES, default 2: number of independent sensor/button channels (>=1).
REQ-002 SHALL have parameter CICLOS_ESTABLE, default 500000: clock cycles a new level must hold before acceptance (>=1).
REQ-003 SHALL have parameter ACTIVO_BAJO, default 0: 1 = raw inputs are active-low and are inverted after synchronisation.
REQ-004 SHALL have parameter ANCHO_CONT, default 8: width of each per-channel press counter.
REQ-005 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port entradas  input  N_CANALES  raw asynchronous sensor/button levels.
REQ-008 SHALL have port limpiar_contadores  input  1  synchronous clear of all press counters.
REQ-009 SHALL have port estables  output  N_CANALES  debounced logical level per channel (1 = active).
REQ-010 SHALL have port flanco_subida  output  N_CANALES  one-cycle pulse when estables[i] goes 0->1.
REQ-011 SHALL have port flanco_bajada  output  N_CANALES  one-cycle pulse when estables[i] goes 1->0.
REQ-012 SHALL have port contadores  output  N_CANALES*ANCHO_CONT  press counts; channel i in bits [i*ANCHO_CONT +: ANCHO_CONT].
REQ-013 SHALL have port algun_cambio  output  1  OR of all flanco_subida and flanco_bajada bits.

Function
REQ-014 Each channel SHALL pass entradas[i] through a two-flop synchroniser; inversion (ACTIVO_BAJO=1) applied at the synchroniser output.
REQ-015 Each channel SHALL hold a debounce counter of width clog2(CICLOS_ESTABLE+1); channels fully independent.
REQ-016 Synchronised level == estables[i]: debounce counter SHALL clear to 0 on the next edge.
REQ-017 Synchronised level != estables[i] and counter < CICLOS_ESTABLE-1: counter SHALL increment.
REQ-018 Synchronised level != estables[i] and counter == CICLOS_ESTABLE-1: estables[i] SHALL toggle and counter clear, same edge.
REQ-019 Any glitch back to the accepted level SHALL restart qualification from 0; no partial credit.
REQ-020 Latency: a level held steady SHALL appear on estables[i] at the (CICLOS_ESTABLE+2)th rising edge, counting the first edge that samples the new raw level as edge 1.
REQ-021 flanco_subida[i]/flanco_bajada[i] SHALL be registered, high for exactly one cycle, asserted in the same cycle estables[i] first shows the new value.
REQ-022 Per-channel press counter SHALL increment by 1 on the same edge that estables[i] rises; contadores shows the new value in the flanco_subida cycle.
REQ-023 Press counters SHALL saturate at 2^ANCHO_CONT-1; no wrap-around.
REQ-024 limpiar_contadores high at an edge SHALL clear all press counters to 0, overriding a coincident increment (result 0).
REQ-025 algun_cambio SHALL be combinational from registered pulses, high for one cycle even when several channels change simultaneously.
REQ-026 Simultaneous transitions on several channels SHALL each produce their own pulse and increment in the same cycle.

Reset
REQ-027 reset high SHALL immediately, independent of clk: estables=0, all pulses=0, algun_cambio=0, contadores=0, debounce counters=0, synchroniser flops at inactive raw level (ACTIVO_BAJO ? 1 : 0).
REQ-028 Reset mid-qualification SHALL discard the partial count.
REQ-029 Input already active at reset release SHALL be qualified normally (REQ-020 counted from first post-release edge), producing flanco_subida and a count increment.

Verification (N_CANALES=2, CICLOS_ESTABLE=4, ACTIVO_BAJO=0, ANCHO_CONT=2 unless stated)
REQ-030 entradas[0] 0->1 held -> estables[0]=1 at edge 6; flanco_subida[0] and algun_cambio high that cycle only; contadores[0]=1; channel 1 unchanged.
REQ-031 entradas[0] high 3 cycles, low 1, high 3, low -> estables[0] stays 0, no pulses; then held high -> rises at edge 6 after final transition.
REQ-032 Five full presses on channel 1 -> contadores[1] = 1,2,3,3,3; limpiar_contadores -> 0; limpiar coincident with a rising edge of estables[1] -> contadores[1]=0, flanco_subida[1] still pulses.
REQ-033 ACTIVO_BAJO=1: reset with entradas=2'b11 -> estables=00, no pulses; entradas[0]=0 held -> estables[0]=1 at edge 6; back to 1 held -> flanco_bajada[0] pulse at edge 6.
REQ-034 reset asserted asynchronously between edges 3 and 4 of a held press -> all outputs 0 immediately; input still high after release -> estables[0]=1 at post-release edge 6, contadores[0]=1.
REQ-035 Both inputs rise on the same edge and hold -> both flanco_subida bits high in the same single cycle; algun_cambio high exactly one cycle; both counters=1.

Source files
------------

// File: rtl/sensores_multi.sv
// Multi-channel sensor/button conditioner: two-flop synchroniser, debounce,
// edge pulses and saturating press counters per channel.
module sensores_multi #(
    parameter int N_CANALES      = 2,
    parameter int CICLOS_ESTABLE = 500000,
    parameter int ACTIVO_BAJO    = 0,
    parameter int ANCHO_CONT     = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [N_CANALES-1:0]            entradas,
    input  logic                            limpiar_contadores,
    output logic [N_CANALES-1:0]            estables,
    output logic [N_CANALES-1:0]            flanco_subida,
    output logic [N_CANALES-1:0]            flanco_bajada,
    output logic [N_CANALES*ANCHO_CONT-1:0] contadores,
    output logic                            algun_cambio
);

    localparam int ANCHO_DEB = $clog2(CICLOS_ESTABLE + 1);
    localparam logic [ANCHO_DEB-1:0]  DEB_FIN     = ANCHO_DEB'(CICLOS_ESTABLE - 1);
    localparam logic [ANCHO_CONT-1:0] CONT_MAX    = '1;
    localparam logic [N_CANALES-1:0]  SINC_REPOSO = {N_CANALES{ACTIVO_BAJO != 0}};

    logic [N_CANALES-1:0]  r_sinc1;
    logic [N_CANALES-1:0]  r_sinc2;
    logic [N_CANALES-1:0]  r_estables;
    logic [N_CANALES-1:0]  r_subida;
    logic [N_CANALES-1:0]  r_bajada;
    logic [ANCHO_DEB-1:0]  r_deb  [N_CANALES];
    logic [ANCHO_CONT-1:0] r_cont [N_CANALES];
    logic [N_CANALES-1:0]  w_nivel;

    // Polarity is normalised after the synchroniser so everything downstream is active-high.
    assign w_nivel = (ACTIVO_BAJO != 0) ? ~r_sinc2 : r_sinc2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sinc1    <= SINC_REPOSO;
            r_sinc2    <= SINC_REPOSO;
            r_estables <= '0;
            r_subida   <= '0;
            r_bajada   <= '0;
            for (int i = 0; i < N_CANALES; i++) begin
                r_deb[i]  <= '0;
                r_cont[i] <= '0;
            end
        end else begin
            r_sinc1 <= entradas;
            r_sinc2 <= r_sinc1;
            for (int i = 0; i < N_CANALES; i++) begin
                r_subida[i] <= 1'b0;
                r_bajada[i] <= 1'b0;
                if (w_nivel[i] == r_estables[i]) begin
                    r_deb[i] <= '0;
                end else if (r_deb[i] == DEB_FIN) begin
                    r_deb[i]      <= '0;
                    r_estables[i] <= w_nivel[i];
                    r_subida[i]   <= w_nivel[i];
                    r_bajada[i]   <= ~w_nivel[i];
                end else begin
                    r_deb[i] <= r_deb[i] + 1'b1;
                end
                // Clear wins over a coincident press.
                if (limpiar_contadores) begin
                    r_cont[i] <= '0;
                end else if (w_nivel[i] && !r_estables[i] && (r_deb[i] == DEB_FIN)
                             && (r_cont[i] != CONT_MAX)) begin
                    r_cont[i] <= r_cont[i] + 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < N_CANALES; g++) begin : g_cont
        assign contadores[g*ANCHO_CONT +: ANCHO_CONT] = r_cont[g];
    end

    assign estables      = r_estables;
    assign flanco_subida = r_subida;
    assign flanco_bajada = r_bajada;
    assign algun_cambio  = |{r_subida, r_bajada};

endmodule

// File: tb/tb_sensores_multi.sv
// Bench for sensores_multi: directed scenarios with fixed expectations plus a
// randomized run checked against a sliding-window behavioural model.
module tb_sensores_multi;

    localparam int N   = 2;
    localparam int CIC = 4;
    localparam int AC  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset = 1'b1;
    logic [1:0]   entradas = 2'b00;
    logic         limpiar = 1'b0;
    logic [1:0]   est, fs, fb;
    logic [3:0]   cont;
    logic         alg;

    logic         rst_ab = 1'b1;
    logic [1:0]   ent_ab = 2'b11;
    logic         lim_ab = 1'b0;
    logic [1:0]   est_ab, fs_ab, fb_ab;
    logic [3:0]   cont_ab;
    logic         alg_ab;

    sensores_multi #(.N_CANALES(N), .CICLOS_ESTABLE(CIC), .ACTIVO_BAJO(0), .ANCHO_CONT(AC)) u_dut (
        .clk(clk), .reset(reset), .entradas(entradas), .limpiar_contadores(limpiar),
        .estables(est), .flanco_subida(fs), .flanco_bajada(fb),
        .contadores(cont), .algun_cambio(alg)
    );

    sensores_multi #(.N_CANALES(N), .CICLOS_ESTABLE(CIC), .ACTIVO_BAJO(1), .ANCHO_CONT(AC)) u_dut_ab (
        .clk(clk), .reset(rst_ab), .entradas(ent_ab), .limpiar_contadores(lim_ab),
        .estables(est_ab), .flanco_subida(fs_ab), .flanco_bajada(fb_ab),
        .contadores(cont_ab), .algun_cambio(alg_ab)
    );

    int errors = 0;
    int checks = 0;

    // Model: a channel flips when the last CIC synchronised samples all disagree with it.
    logic [1:0] m_est, m_p1, m_p2, m_rise, m_fall;
    logic       m_hist [N][CIC];
    int         m_cnt  [N];

    task automatic model_reset();
        m_est = '0; m_p1 = '0; m_p2 = '0; m_rise = '0; m_fall = '0;
        for (int c = 0; c < N; c++) begin
            m_cnt[c] = 0;
            for (int k = 0; k < CIC; k++) m_hist[c][k] = 1'b0;
        end
    endtask

    task automatic model_edge(input logic [1:0] x, input logic clr);
        logic s;
        logic diff;
        for (int c = 0; c < N; c++) begin
            s = m_p2[c];
            m_p2[c] = m_p1[c];
            m_p1[c] = x[c];
            for (int k = CIC - 1; k > 0; k--) m_hist[c][k] = m_hist[c][k-1];
            m_hist[c][0] = s;
            diff = 1'b1;
            for (int k = 0; k < CIC; k++) if (m_hist[c][k] == m_est[c]) diff = 1'b0;
            m_rise[c] = diff && !m_est[c];
            m_fall[c] = diff && m_est[c];
            if (diff) m_est[c] = ~m_est[c];
            if (clr) m_cnt[c] = 0;
            else if (m_rise[c] && m_cnt[c] < (1 << AC) - 1) m_cnt[c] = m_cnt[c] + 1;
        end
    endtask

    task automatic step(input logic [1:0] x, input logic clr);
        entradas = x;
        limpiar  = clr;
        @(posedge clk);
        model_edge(x, clr);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (est !== 2'b00) begin errors++; $display("FAIL reset_est: got %b expected 00", est); end
        checks++; if ({fs, fb} !== 4'b0) begin errors++; $display("FAIL reset_pulses: got %b expected 0000", {fs, fb}); end
        checks++; if (cont !== 4'b0) begin errors++; $display("FAIL reset_cont: got %h expected 0", cont); end
        checks++; if (alg !== 1'b0) begin errors++; $display("FAIL reset_alg: got %b expected 0", alg); end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_single_press();
        for (int e = 1; e <= 7; e++) begin
            step(2'b01, 1'b0);
            checks++; if (est !== {1'b0, e >= 6}) begin errors++; $display("FAIL press_est e%0d: got %b expected %b", e, est, {1'b0, e >= 6}); end
            checks++; if (fs !== {1'b0, e == 6} || alg !== (e == 6)) begin errors++; $display("FAIL press_pulse e%0d: got fs=%b alg=%b", e, fs, alg); end
            if (e == 6) begin
                checks++; if (cont !== 4'b0001) begin errors++; $display("FAIL press_cont: got %h expected 1", cont); end
            end
        end
        for (int e = 1; e <= 6; e++) begin
            step(2'b00, 1'b0);
            checks++; if (fb !== {1'b0, e == 6}) begin errors++; $display("FAIL release_fb e%0d: got %b expected %b", e, fb, {1'b0, e == 6}); end
        end
    endtask

    task automatic test_glitch();
        logic [10:0] pat;
        pat = 11'b11101110000;
        for (int i = 10; i >= 0; i--) begin
            step({1'b0, pat[i]}, 1'b0);
            checks++; if (est[0] !== 1'b0 || fs[0] !== 1'b0 || fb[0] !== 1'b0) begin
                errors++; $display("FAIL glitch_quiet i%0d: got est=%b fs=%b fb=%b expected 0", i, est[0], fs[0], fb[0]);
            end
        end
        for (int e = 1; e <= 6; e++) begin
            step(2'b01, 1'b0);
            checks++; if (est[0] !== (e == 6)) begin errors++; $display("FAIL glitch_hold e%0d: got %b expected %b", e, est[0], e == 6); end
        end
        repeat (6) step(2'b00, 1'b0);
    endtask

    task automatic test_saturation_clear();
        int exp_c [5];
        exp_c = '{1, 2, 3, 3, 3};
        for (int p = 0; p < 5; p++) begin
            repeat (6) step(2'b10, 1'b0);
            checks++; if (fs[1] !== 1'b1 || int'(cont[3:2]) != exp_c[p]) begin
                errors++; $display("FAIL sat_press%0d: got fs=%b cnt=%0d expected fs=1 cnt=%0d", p, fs[1], cont[3:2], exp_c[p]);
            end
            repeat (6) step(2'b00, 1'b0);
        end
        step(2'b00, 1'b1);
        checks++; if (cont !== 4'b0) begin errors++; $display("FAIL clear: got %h expected 0", cont); end
        repeat (5) step(2'b10, 1'b0);
        step(2'b10, 1'b1);
        checks++; if (fs[1] !== 1'b1 || cont[3:2] !== 2'd0) begin
            errors++; $display("FAIL clear_coincident: got fs=%b cnt=%0d expected fs=1 cnt=0", fs[1], cont[3:2]);
        end
        repeat (6) step(2'b00, 1'b0);
    endtask

    task automatic test_simultaneous();
        step(2'b00, 1'b1);
        for (int e = 1; e <= 7; e++) begin
            step(2'b11, 1'b0);
            checks++; if (fs !== ((e == 6) ? 2'b11 : 2'b00) || alg !== (e == 6)) begin
                errors++; $display("FAIL simul e%0d: got fs=%b alg=%b", e, fs, alg);
            end
            if (e == 6) begin
                checks++; if (cont !== 4'b0101) begin errors++; $display("FAIL simul_cont: got %h expected 5", cont); end
            end
        end
        repeat (6) step(2'b00, 1'b0);
    endtask

    task automatic test_async_reset();
        repeat (6) step(2'b10, 1'b0);
        repeat (3) step(2'b11, 1'b0);
        #3 reset = 1'b1;
        #1;
        checks++; if (est !== 2'b00 || fs !== 2'b00 || fb !== 2'b00 || cont !== 4'b0 || alg !== 1'b0) begin
            errors++; $display("FAIL async_reset: got est=%b fs=%b fb=%b cont=%h alg=%b expected all 0", est, fs, fb, cont, alg);
        end
        @(posedge clk);
        #2 reset = 1'b0;
        model_reset();
        for (int e = 1; e <= 6; e++) begin
            step(2'b11, 1'b0);
            checks++; if (est !== ((e == 6) ? 2'b11 : 2'b00)) begin errors++; $display("FAIL post_reset e%0d: got %b", e, est); end
        end
        checks++; if (cont !== 4'b0101) begin errors++; $display("FAIL post_reset_cont: got %h expected 5", cont); end
        repeat (6) step(2'b00, 1'b0);
    endtask

    task automatic test_random();
        int         hold;
        logic [1:0] val;
        logic       clr;
        logic [3:0] exp_cont;
        hold = 0;
        val  = 2'b00;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (hold == 0) begin
                val  = 2'($urandom_range(0, 3));
                hold = $urandom_range(1, 8);
            end
            hold--;
            clr = ($urandom_range(0, 39) == 0);
            step(val, clr);
            exp_cont = {2'(m_cnt[1]), 2'(m_cnt[0])};
            checks++; if (est !== m_est) begin errors++; $display("FAIL rnd_est c%0d: got %b expected %b", cyc, est, m_est); end
            checks++; if (fs !== m_rise) begin errors++; $display("FAIL rnd_fs c%0d: got %b expected %b", cyc, fs, m_rise); end
            checks++; if (fb !== m_fall) begin errors++; $display("FAIL rnd_fb c%0d: got %b expected %b", cyc, fb, m_fall); end
            checks++; if (cont !== exp_cont) begin errors++; $display("FAIL rnd_cont c%0d: got %h expected %h", cyc, cont, exp_cont); end
            checks++; if (alg !== |{m_rise, m_fall}) begin errors++; $display("FAIL rnd_alg c%0d: got %b expected %b", cyc, alg, |{m_rise, m_fall}); end
        end
    endtask

    task automatic test_activo_bajo();
        ent_ab = 2'b11;
        rst_ab = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (est_ab !== 2'b00 || alg_ab !== 1'b0) begin errors++; $display("FAIL ab_reset: got est=%b alg=%b expected 00/0", est_ab, alg_ab); end
        @(negedge clk);
        rst_ab = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk); #1;
            checks++; if (est_ab !== 2'b00 || fs_ab !== 2'b00 || fb_ab !== 2'b00) begin
                errors++; $display("FAIL ab_idle e%0d: got est=%b fs=%b fb=%b", e, est_ab, fs_ab, fb_ab);
            end
        end
        ent_ab = 2'b10;
        for (int e = 1; e <= 7; e++) begin
            @(posedge clk); #1;
            checks++; if (est_ab !== {1'b0, e >= 6} || fs_ab !== {1'b0, e == 6}) begin
                errors++; $display("FAIL ab_press e%0d: got est=%b fs=%b", e, est_ab, fs_ab);
            end
        end
        ent_ab = 2'b11;
        for (int e = 1; e <= 7; e++) begin
            @(posedge clk); #1;
            checks++; if (est_ab !== {1'b0, e < 6} || fb_ab !== {1'b0, e == 6}) begin
                errors++; $display("FAIL ab_release e%0d: got est=%b fb=%b", e, est_ab, fb_ab);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_press();
        test_glitch();
        test_saturation_clear();
        test_simultaneous();
        test_async_reset();
        test_random();
        test_activo_bajo();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
